// File: rtl/lsu_mem_bridge.sv
// Bridge between a single-issue load/store unit and a synchronous single-port data SRAM.
// Handles lane steering, sign extension and misalignment/range faults with a 4-state FSM.
module lsu_mem_bridge #(
   parameter int AW = 12
) (
   input  logic          i_CLK,
   input  logic          i_RST,
   input  logic          i_LSU_REQ,
   input  logic          i_LSU_WE,
   input  logic [1:0]    i_LSU_HB,
   input  logic [31:0]   i_LSU_ADDR,
   input  logic [31:0]   i_LSU_WDATA,
   output logic [31:0]   o_LSU_RDATA,
   output logic          o_LSU_GNT,
   output logic          o_LSU_ERR,
   output logic          o_MEM_CE,
   output logic          o_MEM_WE,
   output logic [3:0]    o_MEM_BE,
   output logic [AW-1:0] o_MEM_ADDR,
   output logic [31:0]   o_MEM_WDATA,
   input  logic [31:0]   i_MEM_RDATA
);

   localparam logic [1:0] HB_BYTE = 2'b00;
   localparam logic [1:0] HB_HALF = 2'b01;
   localparam logic [1:0] HB_WORD = 2'b10;
   localparam logic [1:0] HB_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10,
      FAULT  = 2'b11
   } state_t;

   state_t     state;
   logic       req_we;
   logic [1:0] req_hb;
   logic [1:0] req_lane;

   // Address range is checked by shifting so any AW up to 30 stays legal.
   function automatic logic is_fault(input logic [1:0] hb, input logic [31:0] addr);
      logic bad;
      bad = 1'b0;
      if (hb == HB_ILL)                              bad = 1'b1;
      if ((hb == HB_HALF) && addr[0])                bad = 1'b1;
      if ((hb == HB_WORD) && (addr[1:0] != 2'b00))   bad = 1'b1;
      if ((addr >> (AW + 2)) != 32'd0)               bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] hb, input logic [1:0] lane);
      logic [3:0] be;
      case (hb)
         HB_BYTE: be = 4'b0001 << lane;
         HB_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] hb, input logic [31:0] wdata);
      logic [31:0] wd;
      case (hb)
         HB_BYTE: wd = {4{wdata[7:0]}};
         HB_HALF: wd = {2{wdata[15:0]}};
         default: wd = wdata;
      endcase
      return wd;
   endfunction

   function automatic logic [31:0] load_extend(input logic [1:0] hb, input logic [1:0] lane,
                                               input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [31:0] ext;
      shifted = rdata >> {lane, 3'b000};
      case (hb)
         HB_BYTE: ext = {{24{shifted[7]}}, shifted[7:0]};
         HB_HALF: ext = lane[1] ? {{16{rdata[31]}}, rdata[31:16]}
                                : {{16{rdata[15]}}, rdata[15:0]};
         default: ext = rdata;
      endcase
      return ext;
   endfunction

   // SRAM read data arrives in RESP, so load data is steered combinationally from it.
   assign o_LSU_RDATA = ((state == RESP) && !req_we) ? load_extend(req_hb, req_lane, i_MEM_RDATA)
                                                     : 32'd0;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state       <= IDLE;
         req_we      <= 1'b0;
         req_hb      <= 2'b00;
         req_lane    <= 2'b00;
         o_LSU_GNT   <= 1'b0;
         o_LSU_ERR   <= 1'b0;
         o_MEM_CE    <= 1'b0;
         o_MEM_WE    <= 1'b0;
         o_MEM_BE    <= 4'b0000;
         o_MEM_ADDR  <= '0;
         o_MEM_WDATA <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               o_LSU_GNT <= 1'b0;
               o_LSU_ERR <= 1'b0;
               if (i_LSU_REQ) begin
                  req_we   <= i_LSU_WE;
                  req_hb   <= i_LSU_HB;
                  req_lane <= i_LSU_ADDR[1:0];
                  if (is_fault(i_LSU_HB, i_LSU_ADDR)) begin
                     state     <= FAULT;
                     o_LSU_GNT <= 1'b1;
                     o_LSU_ERR <= 1'b1;
                  end else begin
                     state       <= ACCESS;
                     o_MEM_CE    <= 1'b1;
                     o_MEM_WE    <= i_LSU_WE;
                     o_MEM_BE    <= lane_be(i_LSU_HB, i_LSU_ADDR[1:0]);
                     o_MEM_ADDR  <= i_LSU_ADDR[AW+1:2];
                     o_MEM_WDATA <= lane_wdata(i_LSU_HB, i_LSU_WDATA);
                  end
               end
            end
            ACCESS: begin
               state     <= RESP;
               o_MEM_CE  <= 1'b0;
               o_MEM_WE  <= 1'b0;
               o_MEM_BE  <= 4'b0000;
               o_LSU_GNT <= 1'b1;
               o_LSU_ERR <= 1'b0;
            end
            RESP: begin
               state     <= IDLE;
               o_LSU_GNT <= 1'b0;
            end
            FAULT: begin
               state     <= IDLE;
               o_LSU_GNT <= 1'b0;
               o_LSU_ERR <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: directed LSU accesses against a behavioural SRAM,
// with expected GNT responses and SRAM cycles queued by the driver and checked by a monitor.
module tb_lsu_mem_bridge;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          lsu_we;
   logic [1:0]    lsu_hb;
   logic [31:0]   lsu_addr;
   logic [31:0]   lsu_wdata;
   logic [31:0]   lsu_rdata;
   logic          gnt;
   logic          err;
   logic          mem_ce;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   lsu_mem_bridge #(.AW(AW)) dut (
      .i_CLK       (clk),
      .i_RST       (rst),
      .i_LSU_REQ   (req),
      .i_LSU_WE    (lsu_we),
      .i_LSU_HB    (lsu_hb),
      .i_LSU_ADDR  (lsu_addr),
      .i_LSU_WDATA (lsu_wdata),
      .o_LSU_RDATA (lsu_rdata),
      .o_LSU_GNT   (gnt),
      .o_LSU_ERR   (err),
      .o_MEM_CE    (mem_ce),
      .o_MEM_WE    (mem_we),
      .o_MEM_BE    (mem_be),
      .o_MEM_ADDR  (mem_addr),
      .o_MEM_WDATA (mem_wdata),
      .i_MEM_RDATA (mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          issue;
      int          lat;
      string       name;
   } gnt_exp_t;

   typedef struct {
      logic          we;
      logic [3:0]    be;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      string         name;
   } mem_exp_t;

   gnt_exp_t gq[$];
   mem_exp_t mq[$];
   gnt_exp_t ge;
   mem_exp_t me;

   // Synchronous SRAM: read word appears the cycle after CE with WE=0.
   logic [31:0] sram [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) sram[i] = 32'd0;
      mem_rdata = 32'd0;
   end
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   // Monitor: compares every GNT and every SRAM cycle against the queued expectations.
   always @(negedge clk) begin
      if (gnt) begin
         checks++;
         if (gq.size() == 0) begin
            failures++;
            $display("FAIL gnt_unexpected cyc=%0d rdata=%h err=%b required=no_gnt", cyc, lsu_rdata, err);
         end else begin
            ge = gq.pop_front();
            if (lsu_rdata !== ge.rdata || err !== ge.err || (cyc - ge.issue) != ge.lat) begin
               failures++;
               $display("FAIL gnt_%s rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                        ge.name, lsu_rdata, err, cyc - ge.issue, ge.rdata, ge.err, ge.lat);
            end
         end
      end
      if (mem_ce) begin
         checks++;
         if (mq.size() == 0) begin
            failures++;
            $display("FAIL ce_unexpected cyc=%0d addr=%h be=%b required=no_ce", cyc, mem_addr, mem_be);
         end else begin
            me = mq.pop_front();
            if (mem_we !== me.we || mem_be !== me.be || mem_addr !== me.addr || mem_wdata !== me.wdata) begin
               failures++;
               $display("FAIL mem_%s we=%b be=%b addr=%h wdata=%h required we=%b be=%b addr=%h wdata=%h",
                        me.name, mem_we, mem_be, mem_addr, mem_wdata, me.we, me.be, me.addr, me.wdata);
            end
         end
      end else begin
         checks++;
         if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin
            failures++;
            $display("FAIL idle_strobes cyc=%0d we=%b be=%b required we=0 be=0000", cyc, mem_we, mem_be);
         end
      end
   end

   bit chained = 1'b0;

   task automatic run(input string name, input logic we, input logic [1:0] hb,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd, input bit keep);
      int issue;
      bit seen;
      gnt_exp_t g;
      mem_exp_t m;
      if (!chained) begin
         @(negedge clk);
         issue = cyc;
      end else begin
         issue = cyc + 1;
      end
      req = 1'b1; lsu_we = we; lsu_hb = hb; lsu_addr = addr; lsu_wdata = wdata;
      g.rdata = exp_rdata; g.err = exp_err; g.issue = issue; g.lat = exp_err ? 1 : 2; g.name = name;
      gq.push_back(g);
      if (!exp_err) begin
         m.we = we; m.be = exp_be; m.addr = addr[AW+1:2]; m.wdata = exp_wd; m.name = name;
         mq.push_back(m);
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (gnt) seen = 1'b1;
         else if (cyc > issue) begin
            // Inputs after the latching edge must not influence the access.
            lsu_we = ~we; lsu_hb = 2'b11; lsu_addr = ~addr; lsu_wdata = ~wdata;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL timeout_%s gnt=0 required gnt within 10 cycles", name);
      end
      chained = keep && seen;
      if (!chained) req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; lsu_we = 1'b0; lsu_hb = 2'b00; lsu_addr = 32'd0; lsu_wdata = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt, err, lsu_rdata, mem_ce, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_state gnt=%b err=%b rdata=%h ce=%b we=%b be=%b addr=%h wdata=%h required all 0",
                  gnt, err, lsu_rdata, mem_ce, mem_we, mem_be, mem_addr, mem_wdata);
      end
      rst = 1'b0;

      run("st_w10",  1'b1, 2'b10, 32'h10,    32'h1234_5678, 32'h0,         1'b0, 4'b1111, 32'h1234_5678, 1'b0);
      run("ld_w10",  1'b0, 2'b10, 32'h10,    32'h0,         32'h1234_5678, 1'b0, 4'b1111, 32'h0,         1'b0);
      run("st_b13",  1'b1, 2'b00, 32'h13,    32'h80,        32'h0,         1'b0, 4'b1000, 32'h8080_8080, 1'b0);
      run("ld_b13",  1'b0, 2'b00, 32'h13,    32'h0,         32'hFFFF_FF80, 1'b0, 4'b1000, 32'h0,         1'b0);
      run("st_w00",  1'b1, 2'b10, 32'h0,     32'h7FFF_0000, 32'h0,         1'b0, 4'b1111, 32'h7FFF_0000, 1'b0);
      run("ld_h02",  1'b0, 2'b01, 32'h2,     32'h0,         32'h0000_7FFF, 1'b0, 4'b1100, 32'h0,         1'b0);

      run("flt_w06", 1'b0, 2'b10, 32'h6,     32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b1);
      run("flt_h01", 1'b0, 2'b01, 32'h1,     32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b1);
      run("flt_hb3", 1'b1, 2'b11, 32'h0,     32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b1);
      run("flt_rng", 1'b0, 2'b10, 32'h1_0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0);

      run("st_h22",  1'b1, 2'b01, 32'h22,    32'hABCD_8001, 32'h0,         1'b0, 4'b1100, 32'h8001_8001, 1'b0);
      run("ld_h22",  1'b0, 2'b01, 32'h22,    32'h0,         32'hFFFF_8001, 1'b0, 4'b1100, 32'h0,         1'b0);
      run("st_b21",  1'b1, 2'b00, 32'h21,    32'h1234_56A5, 32'h0,         1'b0, 4'b0010, 32'hA5A5_A5A5, 1'b0);
      run("ld_b20",  1'b0, 2'b00, 32'h20,    32'h0,         32'h0,         1'b0, 4'b0001, 32'h0,         1'b0);
      run("ld_b21",  1'b0, 2'b00, 32'h21,    32'h0,         32'hFFFF_FFA5, 1'b0, 4'b0010, 32'h0,         1'b0);
      run("ld_b22",  1'b0, 2'b00, 32'h22,    32'h0,         32'h0000_0001, 1'b0, 4'b0100, 32'h0,         1'b0);
      run("ld_b11",  1'b0, 2'b00, 32'h11,    32'h0,         32'h0000_0056, 1'b0, 4'b0010, 32'h0,         1'b0);
      run("ld_h10",  1'b0, 2'b01, 32'h10,    32'h0,         32'h0000_5678, 1'b0, 4'b0011, 32'h0,         1'b0);
      run("ld_w20",  1'b0, 2'b10, 32'h20,    32'h0,         32'h8001_A500, 1'b0, 4'b1111, 32'h0,         1'b0);

      // Abort a store in its ACCESS cycle: no GNT is expected for it.
      @(negedge clk);
      req = 1'b1; lsu_we = 1'b1; lsu_hb = 2'b10; lsu_addr = 32'h30; lsu_wdata = 32'hDEAD_BEEF;
      me.we = 1'b1; me.be = 4'b1111; me.addr = 12'd12; me.wdata = 32'hDEAD_BEEF; me.name = "st_abort";
      mq.push_back(me);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({gnt, err, lsu_rdata, mem_ce, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_abort gnt=%b err=%b rdata=%h ce=%b we=%b be=%b addr=%h wdata=%h required all 0",
                  gnt, err, lsu_rdata, mem_ce, mem_we, mem_be, mem_addr, mem_wdata);
      end
      req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run("ld_after_rst", 1'b0, 2'b10, 32'h10, 32'h0, 32'h8034_5678, 1'b0, 4'b1111, 32'h0, 1'b0);

      run("bb_ld10", 1'b0, 2'b10, 32'h10, 32'h0, 32'h8034_5678, 1'b0, 4'b1111, 32'h0, 1'b1);
      run("bb_ld20", 1'b0, 2'b10, 32'h20, 32'h0, 32'h8001_A500, 1'b0, 4'b1111, 32'h0, 1'b1);
      run("bb_ld00", 1'b0, 2'b10, 32'h0,  32'h0, 32'h7FFF_0000, 1'b0, 4'b1111, 32'h0, 1'b0);

      repeat (5) @(negedge clk);
      checks++;
      if (gq.size() != 0) begin
         failures++;
         $display("FAIL gnt_queue_drain pending=%0d required 0", gq.size());
      end
      checks++;
      if (mq.size() != 0) begin
         failures++;
         $display("FAIL mem_queue_drain pending=%0d required 0", mq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout cyc=%0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
